// File: rtl/ray_block_scheduler.sv
// rtl/ray_block_scheduler.sv - issues one ray against a block list and keeps the nearest intersection hit
module ray_block_scheduler #(
   parameter int MAX_BLOCKS = 64,
   parameter int IDX_W      = 6,
   parameter int RD_LATENCY = 2
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [31:0]      ray_x,
   input  logic [31:0]      ray_y,
   input  logic [31:0]      ray_z,
   input  logic [IDX_W:0]   num_blocks,
   input  logic             ray_valid,
   output logic             ray_ready,
   output logic [IDX_W-1:0] block_addr,
   output logic             block_rd_en,
   input  logic [31:0]      block_pos_x,
   input  logic [31:0]      block_pos_y,
   input  logic [31:0]      block_pos_z,
   output logic [31:0]      isect_ray_x,
   output logic [31:0]      isect_ray_y,
   output logic [31:0]      isect_ray_z,
   output logic [31:0]      isect_block_x,
   output logic [31:0]      isect_block_y,
   output logic [31:0]      isect_block_z,
   output logic             isect_valid,
   input  logic             isect_hit,
   input  logic [31:0]      isect_t,
   input  logic             isect_valid_in,
   output logic             hit_out,
   output logic [IDX_W-1:0] hit_index_out,
   output logic [31:0]      hit_t_out,
   output logic             result_valid,
   input  logic             result_ready
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   localparam logic [IDX_W:0] MAX_N = (IDX_W+1)'(MAX_BLOCKS);
   localparam logic [IDX_W:0] ONE   = (IDX_W+1)'(1);

   state_t                state_q, state_d;
   logic [IDX_W:0]        num_q, num_d;
   logic [IDX_W:0]        issue_cnt_q, issue_cnt_d;
   logic [IDX_W:0]        ret_cnt_q, ret_cnt_d;
   logic [31:0]           ray_x_q, ray_x_d, ray_y_q, ray_y_d, ray_z_q, ray_z_d;
   logic                  best_hit_q, best_hit_d;
   logic [IDX_W-1:0]      best_idx_q, best_idx_d;
   logic [31:0]           best_t_q, best_t_d;
   logic [RD_LATENCY-1:0] rd_dly_q, rd_dly_d;
   logic [IDX_W:0]        num_capped;
   logic                  rd_en;

   // Float-to-unsigned key so that an unsigned compare follows IEEE-754 ordering
   function automatic logic [31:0] ord_key(input logic [31:0] f);
      return f[31] ? ~f : {1'b1, f[30:0]};
   endfunction

   always_comb begin
      state_d     = state_q;
      num_d       = num_q;
      issue_cnt_d = issue_cnt_q;
      ret_cnt_d   = ret_cnt_q;
      ray_x_d     = ray_x_q;
      ray_y_d     = ray_y_q;
      ray_z_d     = ray_z_q;
      best_hit_d  = best_hit_q;
      best_idx_d  = best_idx_q;
      best_t_d    = best_t_q;
      num_capped  = (num_blocks > MAX_N) ? MAX_N : num_blocks;
      rd_en       = (state_q == ISSUE);
      rd_dly_d    = RD_LATENCY'({rd_dly_q, rd_en});

      if ((state_q == ISSUE || state_q == DRAIN) && isect_valid_in) begin
         ret_cnt_d = ret_cnt_q + ONE;
         if (isect_hit && (!best_hit_q || ord_key(isect_t) < ord_key(best_t_q))) begin
            best_hit_d = 1'b1;
            best_idx_d = ret_cnt_q[IDX_W-1:0];
            best_t_d   = isect_t;
         end
      end

      case (state_q)
         IDLE: begin
            if (ray_valid) begin
               ray_x_d     = ray_x;
               ray_y_d     = ray_y;
               ray_z_d     = ray_z;
               num_d       = num_capped;
               issue_cnt_d = '0;
               ret_cnt_d   = '0;
               best_hit_d  = 1'b0;
               best_idx_d  = '0;
               best_t_d    = '0;
               state_d     = (num_capped == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            issue_cnt_d = issue_cnt_q + ONE;
            if (issue_cnt_q == num_q - ONE) state_d = DRAIN;
         end
         DRAIN: begin
            if (isect_valid_in && ret_cnt_q == num_q - ONE) state_d = DONE;
         end
         DONE: begin
            if (result_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q     <= IDLE;
         num_q       <= '0;
         issue_cnt_q <= '0;
         ret_cnt_q   <= '0;
         ray_x_q     <= '0;
         ray_y_q     <= '0;
         ray_z_q     <= '0;
         best_hit_q  <= 1'b0;
         best_idx_q  <= '0;
         best_t_q    <= '0;
         rd_dly_q    <= '0;
      end else begin
         state_q     <= state_d;
         num_q       <= num_d;
         issue_cnt_q <= issue_cnt_d;
         ret_cnt_q   <= ret_cnt_d;
         ray_x_q     <= ray_x_d;
         ray_y_q     <= ray_y_d;
         ray_z_q     <= ray_z_d;
         best_hit_q  <= best_hit_d;
         best_idx_q  <= best_idx_d;
         best_t_q    <= best_t_d;
         rd_dly_q    <= rd_dly_d;
      end
   end

   // Gated by rst_in so the very first reset cycle already shows quiet outputs
   assign ray_ready     = !rst_in && (state_q == IDLE);
   assign result_valid  = !rst_in && (state_q == DONE);
   assign block_rd_en   = !rst_in && rd_en;
   assign block_addr    = rst_in ? '0 : issue_cnt_q[IDX_W-1:0];
   assign isect_valid   = !rst_in && rd_dly_q[RD_LATENCY-1];
   assign isect_ray_x   = rst_in ? '0 : ray_x_q;
   assign isect_ray_y   = rst_in ? '0 : ray_y_q;
   assign isect_ray_z   = rst_in ? '0 : ray_z_q;
   assign isect_block_x = isect_valid ? block_pos_x : '0;
   assign isect_block_y = isect_valid ? block_pos_y : '0;
   assign isect_block_z = isect_valid ? block_pos_z : '0;
   assign hit_out       = !rst_in && best_hit_q;
   assign hit_index_out = rst_in ? '0 : best_idx_q;
   assign hit_t_out     = rst_in ? '0 : best_t_q;

endmodule
